// File: rtl/layer_sequencer_if.sv
// Handshake bundle between the LeNet layer sequencer and its stages / PS side.
// The sequencer uses the slave modport; whoever issues start and owns the stages uses master.
interface layer_sequencer_if #(
    parameter int NUM_STAGES = 6,
    parameter int SEL_W      = 3
);
    logic                  start;
    logic [NUM_STAGES-1:0] stage_finish;
    logic [NUM_STAGES-1:0] stage_rst;
    logic [NUM_STAGES-1:0] stage_en;
    logic [SEL_W-1:0]      bram_sel;
    logic [SEL_W-1:0]      cur_stage;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start,
        output stage_finish,
        input  stage_rst,
        input  stage_en,
        input  bram_sel,
        input  cur_stage,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  start,
        input  stage_finish,
        output stage_rst,
        output stage_en,
        output bram_sel,
        output cur_stage,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/layer_sequencer.sv
// Top-level LeNet layer sequencer: clears, enables and waits on each stage in order.
// Define SEQ_TIMEOUT_EN to build the per-stage watchdog that traps hung stages in ERR.
module layer_sequencer #(
    parameter int NUM_STAGES = 6,
    parameter int SEL_W      = 3,
    parameter int TIMEOUT_W  = 20
) (
    input  logic             clk,
    input  logic             rst,
    layer_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_STAGES-1:0] r_stage_rst;
    logic [NUM_STAGES-1:0] r_stage_en;
    logic [NUM_STAGES-1:0] w_stage_rst_nxt;
    logic [NUM_STAGES-1:0] w_stage_en_nxt;
    logic [SEL_W-1:0]      r_bram_sel;
    logic [SEL_W-1:0]      r_cur_stage;
    logic [SEL_W-1:0]      w_bram_sel_nxt;
    logic [SEL_W-1:0]      w_cur_stage_nxt;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    logic [NUM_STAGES-1:0] w_cur_onehot;
    logic [NUM_STAGES-1:0] w_next_onehot;
    logic [SEL_W-1:0]      w_next_stage;
    logic                  w_finish_cur;
    logic                  w_last_stage;
    logic                  w_expired;

    assign w_cur_onehot  = NUM_STAGES'(1) << r_cur_stage;
    assign w_next_stage  = r_cur_stage + SEL_W'(1);
    assign w_next_onehot = NUM_STAGES'(1) << w_next_stage;
    assign w_finish_cur  = |(bus.stage_finish & w_cur_onehot);
    assign w_last_stage  = (r_cur_stage == SEL_W'(NUM_STAGES - 1));

`ifdef SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_wdog;
    logic                 r_error;

    // Expiry fires on the RUN cycle whose increment would land on all-ones.
    assign w_expired = &(r_wdog + TIMEOUT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog  <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state == S_CLR) begin
                r_wdog <= '0;
            end else if (r_state == S_RUN) begin
                r_wdog <= r_wdog + TIMEOUT_W'(1);
            end
            if (w_state_nxt == S_ERR) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.error = r_error;
`else
    assign w_expired = 1'b0;
    assign bus.error = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_stage_rst_nxt = '0;
        w_stage_en_nxt  = '0;
        w_bram_sel_nxt  = r_bram_sel;
        w_cur_stage_nxt = r_cur_stage;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt     = S_CLR;
                    w_cur_stage_nxt = '0;
                    w_bram_sel_nxt  = '0;
                    w_stage_rst_nxt = NUM_STAGES'(1);
                    w_busy_nxt      = 1'b1;
                    w_done_nxt      = 1'b0;
                end
            end
            S_CLR: begin
                w_state_nxt    = S_RUN;
                w_stage_en_nxt = w_cur_onehot;
            end
            S_RUN: begin
                // Finish takes priority over a watchdog expiry in the same cycle.
                if (w_finish_cur) begin
                    w_state_nxt = S_GAP;
                end else if (w_expired) begin
                    w_state_nxt = S_ERR;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_stage_en_nxt = w_cur_onehot;
                end
            end
            S_GAP: begin
                if (w_last_stage) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt     = S_CLR;
                    w_cur_stage_nxt = w_next_stage;
                    w_bram_sel_nxt  = w_next_stage;
                    w_stage_rst_nxt = w_next_onehot;
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_stage_rst <= '0;
            r_stage_en  <= '0;
            r_bram_sel  <= '0;
            r_cur_stage <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stage_rst <= w_stage_rst_nxt;
            r_stage_en  <= w_stage_en_nxt;
            r_bram_sel  <= w_bram_sel_nxt;
            r_cur_stage <= w_cur_stage_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.stage_rst = r_stage_rst;
    assign bus.stage_en  = r_stage_en;
    assign bus.bram_sel  = r_bram_sel;
    assign bus.cur_stage = r_cur_stage;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with three stages: a cycle vector table plus
// multi-cycle sequences driven by a simple stage model.
`timescale 1ns/1ps
module tb_layer_sequencer;

    localparam int NS = 3;
    localparam int SW = 3;
    localparam int TW = 4;

    typedef struct {
        logic          start;
        logic [NS-1:0] fin;
        logic [NS-1:0] eRst;
        logic [NS-1:0] eEn;
        logic [SW-1:0] eSel;
        logic [SW-1:0] eCur;
        logic          eBusy;
        logic          eDone;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          modelOn;
    logic [NS-1:0] tableFin;
    logic [NS-1:0] modelFin;
    logic [NS-1:0] staleMask;
    logic [NS-1:0] hangMask;

    int cnt[NS];
    int enCycles[NS];
    int rstCount[NS];
    int rstOrder[8];
    int rstOrderLen;
    int overlap;
    int selBad;
    int errors;
    int checks;

    vec_t vecs[17];

    layer_sequencer_if #(.NUM_STAGES(NS), .SEL_W(SW)) bus ();

    layer_sequencer #(
        .NUM_STAGES(NS),
        .SEL_W     (SW),
        .TIMEOUT_W (TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    assign bus.stage_finish = modelOn ? modelFin : tableFin;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stage model: sticky finish raised in the 6th enabled cycle, cleared by stage_rst.
    always @(negedge clk) begin
        if (!modelOn) begin
            modelFin    = staleMask;
            rstOrderLen = 0;
            overlap     = 0;
            selBad      = 0;
            for (int i = 0; i < NS; i++) begin
                cnt[i]      = 0;
                enCycles[i] = 0;
                rstCount[i] = 0;
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (bus.stage_rst[i] && bus.stage_en[i]) overlap++;
                if (bus.stage_rst[i]) begin
                    modelFin[i] = 1'b0;
                    cnt[i]      = 0;
                    rstCount[i]++;
                    if (rstOrderLen < 8) begin
                        rstOrder[rstOrderLen] = i;
                        rstOrderLen++;
                    end
                end else if (bus.stage_en[i]) begin
                    cnt[i]++;
                    enCycles[i]++;
                    if (int'(bus.bram_sel) != i) selBad++;
                    if (cnt[i] == 6 && !hangMask[i]) modelFin[i] = 1'b1;
                end
            end
        end
    end

    function automatic logic [31:0] outVec();
        return {17'b0, bus.stage_rst, bus.stage_en, bus.bram_sel, bus.cur_stage,
                bus.busy, bus.done, bus.error};
    endfunction

    function automatic logic [31:0] packOut(logic [NS-1:0] r, logic [NS-1:0] e,
                                            logic [SW-1:0] s, logic [SW-1:0] c,
                                            logic b, logic d, logic er);
        return {17'b0, r, e, s, c, b, d, er};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.start = v.start;
        tableFin  = v.fin;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        modelOn = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int doneAt;
        int found;
        int errAt;

        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        tableFin  = '0;
        modelOn   = 1'b0;
        staleMask = '0;
        hangMask  = '0;

        vecs[0]  = '{1'b1, 3'b000, 3'b001, 3'b000, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 3'b000, 3'b001, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 3'b100, 3'b000, 3'b001, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 3'b010, 3'b000, 3'b001, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 3'b001, 3'b000, 3'b000, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 3'b001, 3'b010, 3'b000, 3'd1, 3'd1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 3'b011, 3'b000, 3'b010, 3'd1, 3'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 3'b001, 3'b000, 3'b010, 3'd1, 3'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 3'b011, 3'b000, 3'b000, 3'd1, 3'd1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 3'b011, 3'b100, 3'b000, 3'd2, 3'd2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 3'b011, 3'b000, 3'b100, 3'd2, 3'd2, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 3'b111, 3'b000, 3'b000, 3'd2, 3'd2, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 3'b111, 3'b000, 3'b000, 3'd2, 3'd2, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 3'b111, 3'b000, 3'b000, 3'd2, 3'd2, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 3'b000, 3'b001, 3'b000, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 3'b000, 3'b000, 3'b001, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 3'b000, 3'b000, 3'b001, 3'd0, 3'd0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset state", outVec(), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vector %0d", i), outVec(),
                        packOut(vecs[i].eRst, vecs[i].eEn, vecs[i].eSel, vecs[i].eCur,
                                vecs[i].eBusy, vecs[i].eDone, 1'b0));
        end
        bus.start = 1'b0;
        tableFin  = '0;

        // Full run with stale finish on stage 1 and a stray start during its RUN.
        staleMask = 3'b010;
        hangMask  = '0;
        doReset();
        modelOn = 1'b1;
        pulseStart();
        checkOutput("start latency", outVec(),
                    packOut(3'b001, 3'b000, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0));
        doneAt = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            bus.start = (n == 11);
            @(posedge clk);
            #1;
            if (bus.done) begin
                doneAt = n;
                break;
            end
        end
        bus.start = 1'b0;
        checkOutput("cycles to done", doneAt, 24);
        checkOutput("done outputs", outVec(),
                    packOut(3'b000, 3'b000, 3'd2, 3'd2, 1'b0, 1'b1, 1'b0));
        checkOutput("clear order", (rstOrderLen << 12) | (rstOrder[0] << 8) |
                    (rstOrder[1] << 4) | rstOrder[2], 32'h3012);
        for (int i = 0; i < NS; i++) begin
            checkOutput($sformatf("enable cycles stage %0d", i), enCycles[i], 6);
        end
        checkOutput("rst/en overlap", overlap, 0);
        checkOutput("bram_sel while enabled", selBad, 0);

        // Restart from DONE, then abort with rst during stage 2.
        pulseStart();
        checkOutput("restart from done", outVec(),
                    packOut(3'b001, 3'b000, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0));
        found = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.stage_en[2]) begin
                found = 1;
                break;
            end
        end
        checkOutput("reach stage 2", found, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort by rst", outVec(), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pulseStart();
        checkOutput("start after abort", outVec(),
                    packOut(3'b001, 3'b000, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0));

`ifdef SEQ_TIMEOUT_EN
        // Stage 1 never finishes: watchdog traps the sequence in ERR.
        staleMask = '0;
        hangMask  = 3'b010;
        doReset();
        modelOn = 1'b1;
        pulseStart();
        errAt = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.error) begin
                errAt = n;
                break;
            end
        end
        checkOutput("cycles to error", errAt, 24);
        checkOutput("hung stage run cycles", enCycles[1], 15);
        checkOutput("error outputs", outVec(),
                    packOut(3'b000, 3'b000, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1));
        pulseStart();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("start ignored in error", outVec(),
                    packOut(3'b000, 3'b000, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1));
        doReset();
        #1;
        checkOutput("error cleared by rst", outVec(), 32'h0);
`else
        errAt = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
